// File: rtl/is_pkg_uart_controller.sv
// rtl/is_pkg_uart_controller.sv - shared constants and types for the UART controller
//
// Purpose: frame geometry (data width, oversampling ratio), the parity sense
// and the receive FSM state encoding used by the UART receive path.
// Ports: none (package).

package is_pkg_uart_controller;

  // Data bits per character.
  localparam int DATA_W = 8;

  // rx_ce ticks per bit period; must be a power of two and at least 8.
  localparam int OVS = 16;

  // Expected XOR of data bits and parity bit for a good frame (even parity).
  localparam logic PARITY_EVEN = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RSTRB = 3'd1,
    RDT   = 3'd2,
    RPARB = 3'd3,
    RSTB1 = 3'd4,
    RSTB2 = 3'd5
  } rx_state_t;

endpackage

// File: rtl/is_uart_rx_sync.sv
// rtl/is_uart_rx_sync.sv - serial line synchroniser with tick-rate edge detect
//
// Purpose: brings the asynchronous serial line into the clk_i domain with two
// flops, and keeps the synchronised value from the previous oversampling tick
// so the FSM can see a high-to-low transition between ticks.
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous reset, active-high; all flops reset to 1 (idle line)
//   ce_i    in   oversampling strobe; only advances the previous-tick register
//   rxd_i   in   asynchronous serial line
//   rxs_o   out  synchronised line value
//   fall_o  out  line was high on the previous tick and is low now

module is_uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic rxd_i,
  output logic rxs_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic rxs_q, rxs_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rxd_i;
    rxs_d  = meta_q;
    // The previous value is taken per tick, not per clock, so a slow edge
    // spread over several clocks still registers as one transition.
    prev_d = ce_i ? rxs_q : prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      rxs_q  <= rxs_d;
      prev_q <= prev_d;
    end
  end

  assign rxs_o  = rxs_q;
  assign fall_o = prev_q & ~rxs_q;

endmodule

// File: rtl/is_uart_rx_fsm.sv
// rtl/is_uart_rx_fsm.sv - UART receive framing FSM (start, data LSB first, even parity, two stops)
//
// Purpose: samples the synchronised line at mid-bit using the oversampling
// strobe, deserialises one character per frame and hands it to the register
// layer with a level valid, parity/framing flags and a sticky overrun flag.
// Ports:
//   clk_i        in   system clock
//   rstn_i       in   asynchronous reset, active-high (asserted = 1)
//   rx_ce_i      in   oversampling strobe, OVS pulses per bit period
//   rxd_i        in   asynchronous serial line, idle high
//   rx_ack_i     in   consumer took the byte; clears valid and flags
//   rx_data_r_o  out  received byte, held until the next delivery
//   rx_vld_r_o   out  byte available (level)
//   rx_perr_r_o  out  parity error for the held byte
//   rx_ferr_r_o  out  framing error (a stop bit sampled low) for the held byte
//   rx_ovr_r_o   out  sticky overrun: delivery while a byte was still pending
//   rx_busy_o    out  FSM not in IDLE

module is_uart_rx_fsm
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W = is_pkg_uart_controller::DATA_W,
  parameter int OVS    = is_pkg_uart_controller::OVS
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              rx_ce_i,
  input  logic              rxd_i,
  input  logic              rx_ack_i,
  output logic [DATA_W-1:0] rx_data_r_o,
  output logic              rx_vld_r_o,
  output logic              rx_perr_r_o,
  output logic              rx_ferr_r_o,
  output logic              rx_ovr_r_o,
  output logic              rx_busy_o
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] HALF_M1  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic rxs;
  logic fall;

  rx_state_t         state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              perr_nx_q, perr_nx_d;
  logic              ferr_nx_q, ferr_nx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  is_uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_i  (rstn_i),
    .ce_i   (rx_ce_i),
    .rxd_i  (rxd_i),
    .rxs_o  (rxs),
    .fall_o (fall)
  );

  // Mid-bit sample point: half a bit after the start edge, then every full bit.
  logic half_hit;
  logic full_hit;
  assign half_hit = rx_ce_i && (tick_q == HALF_M1);
  assign full_hit = rx_ce_i && (tick_q == FULL_M1);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    perr_nx_d = perr_nx_q;
    ferr_nx_d = ferr_nx_q;
    data_d    = data_q;
    vld_d     = vld_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;

    // A standalone ack releases the held byte; a delivery below overrides it.
    if (rx_ack_i && vld_q) begin
      vld_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a line stuck low
        // after a break cannot retrigger until it has gone high again.
        if (rx_ce_i && fall) begin
          tick_d  = '0;
          state_d = RSTRB;
        end
      end

      RSTRB: begin
        if (rx_ce_i) tick_d = tick_q + TW'(1);
        if (half_hit) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            tick_d    = '0;
            bit_d     = '0;
            par_d     = 1'b0;
            perr_nx_d = 1'b0;
            ferr_nx_d = 1'b0;
            state_d   = RDT;
          end
        end
      end

      RDT: begin
        if (rx_ce_i) tick_d = tick_q + TW'(1);
        if (full_hit) begin
          tick_d  = '0;
          shift_d = {rxs, shift_q[DATA_W-1:1]};
          par_d   = par_q ^ rxs;
          if (bit_q == LAST_BIT) begin
            state_d = RPARB;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end

      RPARB: begin
        if (rx_ce_i) tick_d = tick_q + TW'(1);
        if (full_hit) begin
          tick_d    = '0;
          perr_nx_d = (par_q ^ rxs) ^ PARITY_EVEN;
          state_d   = RSTB1;
        end
      end

      RSTB1: begin
        if (rx_ce_i) tick_d = tick_q + TW'(1);
        if (full_hit) begin
          tick_d    = '0;
          ferr_nx_d = ~rxs;
          state_d   = RSTB2;
        end
      end

      RSTB2: begin
        if (rx_ce_i) tick_d = tick_q + TW'(1);
        if (full_hit) begin
          tick_d  = '0;
          data_d  = shift_q;
          vld_d   = 1'b1;
          perr_d  = perr_nx_q;
          ferr_d  = ferr_nx_q | ~rxs;
          // Sticky while unacknowledged; a coincident ack clears it.
          ovr_d   = rx_ack_i ? 1'b0 : (ovr_q | vld_q);
          // Returning mid-stop2 lets the next start edge be caught on time.
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      perr_nx_q <= 1'b0;
      ferr_nx_q <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      perr_nx_q <= perr_nx_d;
      ferr_nx_q <= ferr_nx_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_r_o = data_q;
  assign rx_vld_r_o  = vld_q;
  assign rx_perr_r_o = perr_q;
  assign rx_ferr_r_o = ferr_q;
  assign rx_ovr_r_o  = ovr_q;
  assign rx_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// tb/tb_is_uart_rx_fsm.sv - self-checking bench for is_uart_rx_fsm

module tb_is_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       rxd;
  logic       ack;
  logic [7:0] data;
  logic       vld;
  logic       perr;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  is_uart_rx_fsm dut (
    .clk_i       (clk),
    .rstn_i      (rst),
    .rx_ce_i     (ce),
    .rxd_i       (rxd),
    .rx_ack_i    (ack),
    .rx_data_r_o (data),
    .rx_vld_r_o  (vld),
    .rx_perr_r_o (perr),
    .rx_ferr_r_o (ferr),
    .rx_ovr_r_o  (ovr),
    .rx_busy_o   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       pb;
    logic       s2;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // One oversampling tick: line value settles through the synchroniser, then
  // a single-clock strobe (optionally with ack on the same edge).
  task automatic tick(input logic v, input logic a);
    rxd = v;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 ce = 1'b1;
    ack = a;
    @(posedge clk);
    #1 ce = 1'b0;
    ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  // Full 12-bit frame, 16 ticks per bit; tick 0 is the start edge.
  task automatic run_frame(input logic [7:0] d, input logic pb, input logic s2,
                           input logic ack_dlv, input logic chk_t);
    logic [11:0] fr;
    fr = {s2, 1'b1, pb, d, 1'b0};
    for (int k = 0; k < 192; k++) begin
      tick(fr[k/16], ack_dlv && (k == 184));
      if (chk_t && k == 183) chk("vld_low_at_tick183", 32'(vld), 32'd0);
      if (chk_t && k == 184) begin
        @(posedge clk);
        #1;
        chk("vld_high_after_tick184", 32'(vld), 32'd1);
        chk("data_after_tick184", 32'(data), 32'(d));
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] fr;

    vecs[0] = '{"a5_clean",      8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{"01_bad_parity", 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{"3c_stop2_low",  8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{"ff_clean",      8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{"80_clean",      8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{"7f_bad_parity", 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};

    rst = 1'b1;
    ce  = 1'b0;
    rxd = 1'b1;
    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_vld",  32'(vld),  32'd0);
    chk("reset_perr", 32'(perr), 32'd0);
    chk("reset_ferr", 32'(ferr), 32'd0);
    chk("reset_ovr",  32'(ovr),  32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(20);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d, vecs[i].pb, vecs[i].s2, 1'b0, i == 0);
      idle(8);
      chk({vecs[i].name, "_data"}, 32'(data), 32'(vecs[i].ed));
      chk({vecs[i].name, "_vld"},  32'(vld),  32'd1);
      chk({vecs[i].name, "_perr"}, 32'(perr), 32'(vecs[i].ep));
      chk({vecs[i].name, "_ferr"}, 32'(ferr), 32'(vecs[i].ef));
      chk({vecs[i].name, "_ovr"},  32'(ovr),  32'd0);
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      do_ack();
      chk({vecs[i].name, "_ack_vld"},  32'(vld),  32'd0);
      chk({vecs[i].name, "_ack_perr"}, 32'(perr), 32'd0);
      chk({vecs[i].name, "_ack_ferr"}, 32'(ferr), 32'd0);
    end

    // 3-tick glitch: false start rejected at the half-bit sample (tick 8).
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 3; k < 8; k++) tick(1'b1, 1'b0);
    chk("glitch_busy_tick7", 32'(busy), 32'd1);
    tick(1'b1, 1'b0);
    chk("glitch_busy_tick8", 32'(busy), 32'd0);
    idle(200);
    chk("glitch_no_delivery", 32'(vld), 32'd0);

    // Back-to-back frames without ack -> overrun; then coincident ack.
    run_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_data", 32'(data), 32'h22);
    chk("ovr_vld",  32'(vld),  32'd1);
    chk("ovr_set",  32'(ovr),  32'd1);
    run_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("coack_data", 32'(data), 32'h33);
    chk("coack_vld",  32'(vld),  32'd1);
    chk("coack_ovr",  32'(ovr),  32'd0);
    chk("coack_perr", 32'(perr), 32'd0);
    do_ack();
    chk("coack_ack_vld", 32'(vld), 32'd0);

    // Break: two frame times low -> exactly one delivery (a second would set ovr).
    for (int k = 0; k < 384; k++) tick(1'b0, 1'b0);
    chk("break_vld",  32'(vld),  32'd1);
    chk("break_data", 32'(data), 32'h00);
    chk("break_perr", 32'(perr), 32'd0);
    chk("break_ferr", 32'(ferr), 32'd1);
    chk("break_ovr",  32'(ovr),  32'd0);
    chk("break_busy", 32'(busy), 32'd0);
    idle(16);
    do_ack();
    run_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("after_break_data", 32'(data), 32'h55);
    chk("after_break_vld",  32'(vld),  32'd1);
    chk("after_break_perr", 32'(perr), 32'd0);
    chk("after_break_ferr", 32'(ferr), 32'd0);
    chk("after_break_ovr",  32'(ovr),  32'd0);

    // Reset during data bit 4 with a byte still held.
    fr = {1'b1, 1'b1, 1'b0, 8'hC3, 1'b0};
    for (int k = 0; k < 88; k++) tick(fr[k/16], 1'b0);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #2;
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_vld",  32'(vld),  32'd0);
    chk("midrst_perr", 32'(perr), 32'd0);
    chk("midrst_ferr", 32'(ferr), 32'd0);
    chk("midrst_ovr",  32'(ovr),  32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(16);
    run_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 32'(data), 32'hC3);
    chk("post_rst_vld",  32'(vld),  32'd1);
    chk("post_rst_perr", 32'(perr), 32'd0);
    chk("post_rst_ferr", 32'(ferr), 32'd0);
    chk("post_rst_ovr",  32'(ovr),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/is_uart_rx_fsm.md
Name: is_uart_rx_fsm

Overview:
Receive-side framing FSM of the UART controller; the counterpart to the transmit FSM, consuming the serial line it drives.
Deserialises one frame per character:
- start bit,
- DATA_W data bits, LSB first,
- even parity bit,
- two stop bits.

Samples the line at mid-bit using a 16x oversampling strobe from the baud generator. Presents each byte with a valid/ack handshake and parity, framing and overrun flags to the controller/register layer.

Parameters:
DATA_W, 8 (from is_pkg_uart_controller), data bits per frame
OVS, 16 (from is_pkg_uart_controller), rx_ce_i ticks per bit; power of two, >= 8

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous reset, active-high (asserted = 1)
rx_ce_i  input  1  oversampling strobe, one clk_i pulse per OVS-th of a bit period
rxd_i  input  1  asynchronous serial line, idle high
rx_ack_i  input  1  consumer has taken rx_data_r_o; clears rx_vld_r_o and flags
rx_data_r_o  output  DATA_W  received byte, held until next delivery
rx_vld_r_o  output  1  byte available (level)
rx_perr_r_o  output  1  parity error for the held byte
rx_ferr_r_o  output  1  framing error (a stop bit sampled low) for the held byte
rx_ovr_r_o  output  1  sticky overrun: a byte was delivered while rx_vld_r_o was still set
rx_busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rstn_i=1):
  - state=IDLE; tick and bit counters=0; shift register=0.
  - Synchroniser and edge flops=1.
  - rx_data_r_o=0; rx_vld_r_o, rx_perr_r_o, rx_ferr_r_o, rx_ovr_r_o=0.
  - Reset mid-frame discards the frame; no flags are set.
- Input path: rxd_i passes through a 2-flop synchroniser on every clk_i (not gated by rx_ce_i). All FSM decisions use the synchronised value rxs, and only on clk_i edges where rx_ce_i=1.
- States: IDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2.
- IDLE:
  - On an rx_ce_i tick with rxs=0 and previous-tick rxs=1 (falling edge): tick counter=0, go to RSTRB.
  - A low line without a preceding high never starts a frame (break/stuck-low protection).
- RSTRB: count ticks; at tick OVS/2 sample rxs.
  - If rxs=1: false start, return to IDLE, no output change.
  - If rxs=0: reset tick counter, bit counter=0, go to RDT.
- RDT: every OVS ticks, sample rxs into the shift register MSB and shift right (LSB-first reception); accumulate XOR parity.
  - After DATA_W samples go to RPARB.
- RPARB: after OVS ticks, sample the parity bit. perr_next = XOR of data bits XOR sampled bit (even parity). Go to RSTB1.
- RSTB1: after OVS ticks, sample; a low sample sets ferr_next. Go to RSTB2.
- RSTB2: after OVS ticks, sample; a low sample sets ferr_next. Then deliver and go to IDLE.
- Delivery cycle:
  - Load rx_data_r_o, rx_perr_r_o and rx_ferr_r_o; set rx_vld_r_o=1.
  - If rx_vld_r_o was already 1 and rx_ack_i=0 in the same cycle, also set rx_ovr_r_o=1; the old byte is overwritten.
- Timing:
  - Taking the start-edge tick as tick 0: data bit i is sampled at tick OVS/2+OVS*(i+1).
  - Stop2 is sampled at tick OVS/2+OVS*(DATA_W+3), which is 184 for the defaults.
  - rx_vld_r_o rises on the clk_i edge after that sampling tick.
  - Back-to-back frames are supported: IDLE re-arms during the second half of stop2.
- rx_ack_i:
  - When not coincident with delivery, clears rx_vld_r_o, rx_perr_r_o, rx_ferr_r_o and rx_ovr_r_o on the next edge.
  - When coincident with delivery, delivery wins: vld stays 1, flags come from the new frame, and ovr is cleared.
  - An ack while rx_vld_r_o=0 has no effect.
- Break (line low for a whole frame): delivers data=0x00, perr=0, ferr=1. No new frame starts until the line has returned high.
- rx_busy_o = (state != IDLE), combinational from the state register.
- Undefined state encodings return to IDLE.

Decomposition:
- is_pkg_uart_controller holds:
  - DATA_W and OVS;
  - rx_state_t enum (IDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2; 3-bit);
  - PARITY_EVEN constant.
- Sub-module is_uart_rx_sync contains the 2-flop synchroniser plus the previous-tick register, and outputs rxs and fall_o. Same clock and reset, with reset value 1.

Test Plan:
- Frame 0xA5, parity bit 0, stops 1,1 at OVS=16 -> rx_vld_r_o=1 with rx_data_r_o=0xA5 exactly 184 rx_ce ticks after the start edge; perr=0, ferr=0; ack clears vld.
- Frame 0x01 with parity bit 0 (wrong) -> data=0x01, rx_perr_r_o=1, ferr=0.
- Frame 0x3C with stop2 driven low -> ferr=1. Separately, a 3-tick low glitch on an idle line -> no delivery and rx_busy_o back to 0 at tick 8.
- Two back-to-back frames 0x11 then 0x22 with no ack -> data=0x22, vld=1, ovr=1. Ack coincident with the second delivery -> ovr=0.
- Line held low for 2 frame times -> exactly one delivery with 0x00, ferr=1; then 0x55 after the line returns high -> 0x55 clean.
- rstn_i pulsed high during data bit 4 -> all outputs 0 immediately. A following 0xC3 frame is received correctly.
